// File: rtl/aes_inv_mixcolumns_iter.sv
// Iterative AES InvMixColumns: one 128-bit state per valid/ready transaction,
// COLS_PER_CYCLE columns transformed per clock through a shared GF(2^8) column core.
module aes_inv_mixcolumns_iter #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("aes_inv_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   // Counter step and the col_cnt value of the last BUSY cycle (both wrap to 0 when 4 columns/clock).
   localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state;
   logic [1:0]   col_cnt;
   logic [127:0] work;
   logic [127:0] work_next;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // 9/b/d/e multiples assembled from the x2, x4, x8 chain of each input byte.
   function automatic logic [31:0] inv_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ a[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // NOTE: default assignment first so every path drives work_next and no latch is inferred.
   always_comb begin
      work_next = work;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         work_next[(96 - 32*(int'(col_cnt) + k)) +: 32] =
            inv_col(work[(96 - 32*(int'(col_cnt) + k)) +: 32]);
      end
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         col_cnt   <= 2'd0;
         work      <= '0;
         out_state <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work    <= in_state;
                  col_cnt <= 2'd0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               work    <= work_next;
               col_cnt <= col_cnt + STEP;
               if (col_cnt == LAST_CNT) begin
                  out_state <= work_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_mixcolumns_iter.sv
// Bench for aes_inv_mixcolumns_iter: three instances (1, 2, 4 columns per clock), known vectors,
// backpressure, mid-operation reset and randomized forward->inverse round-trips.
module tb_aes_inv_mixcolumns_iter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] in_state  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] out_state [3];
   logic         busy      [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      aes_inv_mixcolumns_iter #(.COLS_PER_CYCLE(1 << g)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_state  (in_state[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_state (out_state[g]),
         .busy      (busy[g])
      );
   end

   typedef struct {
      logic [127:0] vin;
      logic [127:0] vexp;
      string        name;
   } vec_t;

   localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
   localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_2d26314c;

   // Reference: generic shift-and-add GF(2^8) multiply and circulant matrix product.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
      logic [7:0]   coef [4];
      logic [7:0]   acc;
      logic [127:0] r;
      if (inv) begin
         coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      end else begin
         coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      end
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(coef[(j - row + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
            r[127 - 8*(4*c + row) -: 8] = acc;
         end
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic reset_all();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         in_state[i]  = '0;
         out_ready[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Called #1 after a rising edge; returns #1 after a rising edge.
   task automatic run_vec(input int d, input logic [127:0] vin, input logic [127:0] vexp,
                          input string tag);
      int    lat;
      string p;
      p = $sformatf("d%0d %s", d, tag);
      check({p, " in_ready before accept"}, 128'(in_ready[d]), 128'd1);
      in_valid[d] = 1'b1;
      in_state[d] = vin;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      in_state[d] = '1;
      check({p, " busy after accept"}, 128'(busy[d]), 128'd1);
      check({p, " in_ready after accept"}, 128'(in_ready[d]), 128'd0);
      lat = 0;
      while (!out_valid[d] && lat < 16) begin
         @(posedge clk); #1;
         lat++;
      end
      check({p, " latency"}, 128'(lat), 128'(4 >> d));
      check({p, " out_valid"}, 128'(out_valid[d]), 128'd1);
      check({p, " out_state"}, out_state[d], vexp);
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
      check({p, " out_valid after drain"}, 128'(out_valid[d]), 128'd0);
      check({p, " in_ready after drain"}, 128'(in_ready[d]), 128'd1);
      check({p, " busy after drain"}, 128'(busy[d]), 128'd0);
   endtask

   task automatic backpressure_test();
      int t;
      in_valid[0] = 1'b1;
      in_state[0] = V1_IN;
      @(posedge clk); #1;
      // Keep presenting a different state; it must be ignored outside IDLE.
      in_state[0] = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
      t = 0;
      while (!out_valid[0] && t < 16) begin
         @(posedge clk); #1;
         t++;
      end
      check("bp out_valid reached", 128'(out_valid[0]), 128'd1);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("bp stall %0d out_valid", i), 128'(out_valid[0]), 128'd1);
         check($sformatf("bp stall %0d out_state", i), out_state[0], V1_OUT);
         check($sformatf("bp stall %0d in_ready", i), 128'(in_ready[0]), 128'd0);
         @(posedge clk); #1;
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      check("bp out_valid dropped", 128'(out_valid[0]), 128'd0);
      check("bp in_ready restored", 128'(in_ready[0]), 128'd1);
   endtask

   task automatic reset_midop_test();
      logic seen;
      in_valid[0] = 1'b1;
      in_state[0] = V1_IN;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      @(posedge clk); #1;
      check("rst busy before reset", 128'(busy[0]), 128'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("rst out_valid", 128'(out_valid[0]), 128'd0);
      check("rst out_state", out_state[0], 128'd0);
      check("rst in_ready", 128'(in_ready[0]), 128'd1);
      check("rst busy", 128'(busy[0]), 128'd0);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         seen = seen | out_valid[0];
      end
      check("rst no stray output", 128'(seen), 128'd0);
      run_vec(0, V1_IN, V1_OUT, "after reset");
   endtask

   task automatic round_trip(input int d, input int n);
      logic [127:0] q [$];
      int           got;
      fork
         begin : producer
            logic [127:0] orig;
            logic         acc;
            int           t;
            for (int i = 0; i < n; i++) begin
               orig = {$urandom, $urandom, $urandom, $urandom};
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk); #1;
               end
               q.push_back(orig);
               in_valid[d] = 1'b1;
               in_state[d] = mix(orig, 1'b0);
               acc = 1'b0;
               t = 0;
               while (!acc && t < 100) begin
                  acc = in_ready[d];
                  @(posedge clk); #1;
                  t++;
               end
               in_valid[d] = 1'b0;
               in_state[d] = {$urandom, $urandom, $urandom, $urandom};
               if (!acc) begin
                  check($sformatf("d%0d rt accept timeout", d), 128'd0, 128'd1);
                  break;
               end
            end
         end
         begin : consumer
            logic         rdy;
            logic         v;
            logic [127:0] data;
            logic [127:0] exp;
            int           cyc;
            got = 0;
            cyc = 0;
            while (got < n && cyc < n * 40) begin
               rdy = 1'($urandom_range(0, 1));
               out_ready[d] = rdy;
               v    = out_valid[d];
               data = out_state[d];
               @(posedge clk); #1;
               cyc++;
               if (v && rdy) begin
                  got++;
                  if (q.size() == 0) begin
                     check($sformatf("d%0d rt duplicate output", d), data, 128'd0 - 128'd1);
                  end else begin
                     exp = q.pop_front();
                     check($sformatf("d%0d rt item %0d", d, got), data, exp);
                  end
               end
            end
            out_ready[d] = 1'b0;
            check($sformatf("d%0d rt output count", d), 128'(got), 128'(n));
         end
      join
      repeat (4) begin
         @(posedge clk); #1;
      end
      check($sformatf("d%0d rt no extra output", d), 128'(out_valid[d]), 128'd0);
      check($sformatf("d%0d rt queue drained", d), 128'(q.size()), 128'd0);
   endtask

   vec_t tbl [5];

   initial begin
      tbl[0] = '{V1_IN, V1_OUT, "known vector"};
      tbl[1] = '{128'hc6c6c6c6_01010101_00000000_d5d5d7d6,
                 128'hc6c6c6c6_01010101_00000000_d4d4d4d5, "fixed points"};
      tbl[2] = '{128'h0, 128'h0, "all zero"};
      tbl[3] = '{{128{1'b1}}, {128{1'b1}}, "all ones"};
      tbl[4] = '{128'h01000000_00010000_00000100_00000001,
                 128'h0e090d0b_0b0e090d_0d0b0e09_090d0b0e, "unit bytes"};

      reset_all();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("d%0d reset in_ready", d), 128'(in_ready[d]), 128'd1);
         check($sformatf("d%0d reset busy", d), 128'(busy[d]), 128'd0);
         check($sformatf("d%0d reset out_valid", d), 128'(out_valid[d]), 128'd0);
         check($sformatf("d%0d reset out_state", d), out_state[d], 128'd0);
      end

      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 5; i++)
            run_vec(d, tbl[i].vin, tbl[i].vexp, tbl[i].name);

      backpressure_test();
      reset_midop_test();

      round_trip(0, 1000);
      round_trip(1, 200);
      round_trip(2, 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
